// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic op codes, datapath widths and the captured-result record.
// LOGIC_RESULT_PARITY_EN adds a stored parity bit to each result record.
package alu_pkg;

  localparam int ALU_N = 32;
  localparam int TAG_W = 5;

  typedef enum logic [1:0] {
    OP_AND = 2'd0,
    OP_OR  = 2'd1,
    OP_XOR = 2'd2,
    OP_NOR = 2'd3
  } logic_op_t;

  // Occupancy encoded as {skid_valid, main_valid}
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } skid_state_t;

  typedef struct packed {
    logic [ALU_N-1:0] f;
    logic_op_t        op;
    logic [TAG_W-1:0] tag;
    logic             zero;
    logic             neg;
`ifdef LOGIC_RESULT_PARITY_EN
    logic             par;
`endif
  } logic_result_t;

endpackage

// File: rtl/logic_result_skid_if.sv
// Upstream and writeback valid/ready handshake bundle for logic_result_skid.
// LOGIC_RESULT_PARITY_EN adds out_par.
interface logic_result_skid_if #(
  parameter int N     = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_f;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_f;
  logic [1:0]       out_op;
  logic [TAG_W-1:0] out_tag;
  logic             out_zero;
  logic             out_neg;
`ifdef LOGIC_RESULT_PARITY_EN
  logic             out_par;
`endif

  modport slave (
    input  in_valid, in_f, in_op, in_tag, out_ready,
    output in_ready, out_valid, out_f, out_op, out_tag, out_zero, out_neg
`ifdef LOGIC_RESULT_PARITY_EN
    , output out_par
`endif
  );

  modport master (
    output in_valid, in_f, in_op, in_tag, out_ready,
    input  in_ready, out_valid, out_f, out_op, out_tag, out_zero, out_neg
`ifdef LOGIC_RESULT_PARITY_EN
    , input out_par
`endif
  );
endinterface

// File: rtl/result_flags.sv
// Combinational zero / negative (and optional even parity) flags for a logic-unit result.
// LOGIC_RESULT_PARITY_EN enables the par output.
module result_flags #(
  parameter int N = 32
) (
  input  logic [N-1:0] f,
  output logic         zero,
  output logic         neg
`ifdef LOGIC_RESULT_PARITY_EN
  , output logic       par
`endif
);

  assign zero = (f == {N{1'b0}});
  assign neg  = f[N-1];
`ifdef LOGIC_RESULT_PARITY_EN
  assign par  = ^f;
`endif

endmodule

// File: rtl/logic_result_skid.sv
// Registered output stage for the bitwise logic unit with a 2-entry skid buffer.
// N and TAG_W must match alu_pkg widths; LOGIC_RESULT_PARITY_EN adds stored out_par.
module logic_result_skid #(
  parameter int N       = alu_pkg::ALU_N,
  parameter int TAG_W   = alu_pkg::TAG_W,
  parameter int STALL_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  logic_result_skid_if.slave  bus,
  output logic [STALL_W-1:0]  stall_cnt,
  input  logic                stat_clr
);
  import alu_pkg::logic_result_t;
  import alu_pkg::logic_op_t;
  import alu_pkg::skid_state_t;
  import alu_pkg::ST_EMPTY;
  import alu_pkg::ST_ONE;
  import alu_pkg::ST_FULL;

  skid_state_t   state_q, state_d;
  logic_result_t main_q, main_d;
  logic_result_t skid_q, skid_d;
  logic [STALL_W-1:0] stall_q, stall_d;

  logic_result_t new_s;
  logic          accept_s;
  logic          deliver_s;
  logic          zero_s;
  logic          neg_s;
`ifdef LOGIC_RESULT_PARITY_EN
  logic          par_s;
`endif

  result_flags #(.N(N)) u_flags (
    .f    (bus.in_f),
    .zero (zero_s),
    .neg  (neg_s)
`ifdef LOGIC_RESULT_PARITY_EN
    , .par (par_s)
`endif
  );

  // Ready is a function of the skid flop and reset only, so no comb path from out_ready
  assign bus.in_ready = !state_q[1] && !rst;
  assign accept_s     = bus.in_valid && bus.in_ready;
  assign deliver_s    = state_q[0] && bus.out_ready;

  // Assemble the incoming record with its capture-time flags
  always_comb begin
    new_s      = '0;
    new_s.f    = bus.in_f;
    new_s.op   = logic_op_t'(bus.in_op);
    new_s.tag  = bus.in_tag;
    new_s.zero = zero_s;
    new_s.neg  = neg_s;
`ifdef LOGIC_RESULT_PARITY_EN
    new_s.par  = par_s;
`endif
  end

  // Next-state and entry-load decisions
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept_s) begin
          main_d  = new_s;
          state_d = ST_ONE;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && deliver_s) begin
          main_d  = new_s;
        end else if (accept_s) begin
          skid_d  = new_s;
          state_d = ST_FULL;
        end else if (deliver_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_ONE;
        end
      end
      ST_FULL: begin
        if (deliver_s) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase
  end

  // Saturating back-pressure counter; clear beats increment
  always_comb begin
    stall_d = stall_q;
    if (stat_clr) begin
      stall_d = {STALL_W{1'b0}};
    end else if (state_q[0] && !bus.out_ready && (stall_q != {STALL_W{1'b1}})) begin
      stall_d = stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
  end

  // State, entry and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= {STALL_W{1'b0}};
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign bus.out_valid = state_q[0];
  assign bus.out_f     = main_q.f;
  assign bus.out_op    = main_q.op;
  assign bus.out_tag   = main_q.tag;
  assign bus.out_zero  = main_q.zero;
  assign bus.out_neg   = main_q.neg;
`ifdef LOGIC_RESULT_PARITY_EN
  assign bus.out_par   = main_q.par;
`endif
  assign stall_cnt     = stall_q;

endmodule

// File: tb/tb_logic_result_skid.sv
// Directed self-checking bench for logic_result_skid (default 16-bit and 3-bit stall counters).
// Parity checks are built when LOGIC_RESULT_PARITY_EN is defined.
module tb_logic_result_skid;

  logic        clk = 1'b0;
  logic        rst;
  logic        stat_clr;
  logic        stat_clr2;
  logic [15:0] stall_cnt;
  logic [2:0]  stall_cnt2;
  int          total = 0;
  int          bad   = 0;

  logic_result_skid_if #(.N(32), .TAG_W(5)) bif ();
  logic_result_skid_if #(.N(32), .TAG_W(5)) bif2 ();

  logic_result_skid #(.N(32), .TAG_W(5), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bif.slave), .stall_cnt(stall_cnt), .stat_clr(stat_clr)
  );

  logic_result_skid #(.N(32), .TAG_W(5), .STALL_W(3)) dut2 (
    .clk(clk), .rst(rst), .bus(bif2.slave), .stall_cnt(stall_cnt2), .stat_clr(stat_clr2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] f, input logic [4:0] tag);
    bif.in_valid = v;
    bif.in_f     = f;
    bif.in_tag   = tag;
    bif.in_op    = 2'd2;
  endtask

  initial begin
    rst = 1'b1; stat_clr = 1'b0; stat_clr2 = 1'b0;
    drive(1'b0, 32'h0, 5'd0);
    bif.out_ready = 1'b0;
    bif2.in_valid = 1'b0; bif2.in_f = 32'h0; bif2.in_op = 2'd0; bif2.in_tag = 5'd0;
    bif2.out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", {63'd0, bif.out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, bif.in_ready}, 64'd0);
    check("rst_out_f", {32'd0, bif.out_f}, 64'd0);
    check("rst_stall", {48'd0, stall_cnt}, 64'd0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", {63'd0, bif.in_ready}, 64'd1);

    // streaming at full rate
    bif.out_ready = 1'b1;
    drive(1'b1, 32'h0000_00FF, 5'd1);
    tick();
    check("s1_f", {32'd0, bif.out_f}, 64'h0000_00FF);
    check("s1_zn", {62'd0, bif.out_zero, bif.out_neg}, 64'd0);
    check("s1_op", {62'd0, bif.out_op}, 64'd2);
    drive(1'b1, 32'hFFFF_0000, 5'd2);
    tick();
    check("s2_f", {32'd0, bif.out_f}, 64'hFFFF_0000);
    check("s2_zn", {62'd0, bif.out_zero, bif.out_neg}, 64'd1);
    check("s2_ready", {63'd0, bif.in_ready}, 64'd1);
    drive(1'b1, 32'h0, 5'd3);
    tick();
    check("s3_tag", {59'd0, bif.out_tag}, 64'd3);
    check("s3_zn", {62'd0, bif.out_zero, bif.out_neg}, 64'd2);
    drive(1'b0, 32'h0, 5'd0);
    tick();
    check("s_drain", {63'd0, bif.out_valid}, 64'd0);
    check("s_stall", {48'd0, stall_cnt}, 64'd0);

`ifdef LOGIC_RESULT_PARITY_EN
    drive(1'b1, 32'h0000_0007, 5'd4);
    tick();
    check("par_7", {63'd0, bif.out_par}, 64'd1);
    drive(1'b1, 32'h0000_0003, 5'd5);
    tick();
    check("par_3", {63'd0, bif.out_par}, 64'd0);
    drive(1'b0, 32'h0, 5'd0);
    tick();
`endif

    // back-pressure into the skid entry
    bif.out_ready = 1'b0;
    drive(1'b1, 32'h10, 5'd3);
    tick();
    check("bp_tag3", {59'd0, bif.out_tag}, 64'd3);
    check("bp_ready1", {63'd0, bif.in_ready}, 64'd1);
    drive(1'b1, 32'h20, 5'd7);
    tick();
    check("bp_hold3", {59'd0, bif.out_tag}, 64'd3);
    check("bp_ready0", {63'd0, bif.in_ready}, 64'd0);
    check("bp_stall1", {48'd0, stall_cnt}, 64'd1);
    drive(1'b0, 32'h0, 5'd0);
    for (int i = 0; i < 9; i++) tick();
    check("stall_10", {48'd0, stall_cnt}, 64'd10);
    check("bp_data_hold", {32'd0, bif.out_f}, 64'h10);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("stall_clr", {48'd0, stall_cnt}, 64'd0);
    bif.out_ready = 1'b1;
    tick();
    check("bp_tag7", {59'd0, bif.out_tag}, 64'd7);
    check("bp_f7", {32'd0, bif.out_f}, 64'h20);
    check("bp_ready_back", {63'd0, bif.in_ready}, 64'd1);
    tick();
    check("bp_drain", {63'd0, bif.out_valid}, 64'd0);
    check("bp_stall_after", {48'd0, stall_cnt}, 64'd0);

    // accept and deliver in the same cycle reloads main
    drive(1'b1, 32'h1, 5'd4);
    tick();
    drive(1'b1, 32'hA5A5_A5A5, 5'd5);
    tick();
    check("ad_f", {32'd0, bif.out_f}, 64'hA5A5_A5A5);
    check("ad_tag", {59'd0, bif.out_tag}, 64'd5);
    check("ad_zn", {62'd0, bif.out_zero, bif.out_neg}, 64'd1);
    check("ad_ready", {63'd0, bif.in_ready}, 64'd1);
    drive(1'b0, 32'h0, 5'd0);
    tick();
    check("ad_drain", {63'd0, bif.out_valid}, 64'd0);

    // asynchronous reset while FULL
    bif.out_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1);
    tick();
    drive(1'b1, 32'h22, 5'd2);
    tick();
    drive(1'b0, 32'h0, 5'd0);
    check("full_ready0", {63'd0, bif.in_ready}, 64'd0);
    rst = 1'b1;
    #1;
    check("mrst_valid", {63'd0, bif.out_valid}, 64'd0);
    check("mrst_ready", {63'd0, bif.in_ready}, 64'd0);
    check("mrst_stall", {48'd0, stall_cnt}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("mrst_rel_ready", {63'd0, bif.in_ready}, 64'd1);
    tick();
    check("mrst_rel_valid", {63'd0, bif.out_valid}, 64'd0);

    // 3-bit counter saturation
    bif2.in_valid = 1'b1; bif2.in_f = 32'h5; bif2.in_tag = 5'd9;
    tick();
    bif2.in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("sat_6", {61'd0, stall_cnt2}, 64'd6);
    for (int i = 0; i < 6; i++) tick();
    check("sat_7", {61'd0, stall_cnt2}, 64'd7);
    check("sat_tag", {59'd0, bif2.out_tag}, 64'd9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/logic_result_skid.md
Name: logic_result_skid

Overview:
- Registered output stage directly downstream of the N-bit bitwise logic unit (OR/AND/XOR/NOR gate arrays) in the ALU datapath.
- Captures the combinational result F with its op code and tag, and derives zero and negative flags.
- Presents the captured result to writeback over a valid/ready handshake.
- A 2-entry skid buffer absorbs writeback back-pressure without combinational ready paths upstream.

Parameters:
- N, 32, result width in bits; must be ≥ 2.
- TAG_W, 5, width of the destination-register tag carried with each result.
- STALL_W, 16, width of the saturating back-pressure stall counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  logic unit result on in_f is valid this cycle
- in_ready  output  1  stage can accept a result this cycle
- in_f  input  N  result F from the bitwise logic unit
- in_op  input  2  op that produced in_f: 0=AND, 1=OR, 2=XOR, 3=NOR
- in_tag  input  TAG_W  destination tag
- out_valid  output  1  registered result available
- out_ready  input  1  writeback accepts the result
- out_f  output  N  registered result
- out_op  output  2  registered op
- out_tag  output  TAG_W  registered tag
- out_zero  output  1  out_f == 0
- out_neg  output  1  out_f[N-1]
- stall_cnt  output  STALL_W  cycles with out_valid=1 and out_ready=0, saturating
- stat_clr  input  1  synchronous clear of stall_cnt

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs are 0, including out_valid, out_f/op/tag, out_zero, out_neg and stall_cnt. The skid entry is invalid.
- in_ready = !skid_valid && !rst. It depends only on registered state and rst, never on out_ready combinationally.
- Accept on in_valid && in_ready. Deliver on out_valid && out_ready.
- Latency: an accepted result appears on out_* the next cycle when the main entry is empty or is being delivered in the same cycle.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY (00):
    - accept → ONE.
    - otherwise hold.
  - ONE (01):
    - accept with deliver → ONE; main is reloaded with the new result.
    - accept without deliver → FULL; new result goes to skid.
    - deliver without accept → EMPTY.
    - otherwise hold.
  - FULL (11):
    - no accept is possible.
    - deliver → ONE; skid moves to main.
    - otherwise hold.
- Ordering is strictly FIFO. No result is dropped or duplicated.
- Flags are computed from the data at capture time and stored alongside it. out_zero and out_neg always match the out_f being presented.
- Data registers update only on a load. Data is held stable while out_valid=1 and out_ready=0.
- out_ready asserted while out_valid=0 has no effect.
- stall_cnt:
  - increments by 1 each cycle out_valid && !out_ready.
  - saturates at 2^STALL_W−1.
  - stat_clr forces 0 next cycle and wins over a simultaneous increment.
- Reset mid-operation: both entries are invalidated immediately (asynchronous). In-flight results are discarded and stall_cnt clears.
- in_op carries no meaning for this stage; it is passed through unchanged.

Optional Feature:
- Macro: LOGIC_RESULT_PARITY_EN.
- Defined:
  - adds output out_par (1 bit), the even parity XOR-reduction of out_f, computed at capture and stored per entry.
  - resets to 0.
- Undefined: the out_par port and its per-entry storage do not exist. All other behaviour is identical.

Decomposition:
- Shared package alu_pkg holds:
  - the logic_op_t enum (AND=0, OR=1, XOR=2, NOR=3).
  - constants ALU_N=32 and TAG_W=5.
  - a packed struct logic_result_t {f, op, tag, zero, neg[, par]} used for both entries.
- One sub-module, result_flags, is the combinational zero/neg/parity generator from f. It is instantiated once at the input side.

Test Plan:
- Reset: rst=1 mid-stream with FULL state → out_valid=0, in_ready=0 during rst, stall_cnt=0; in_ready=1 the first cycle after release.
- Streaming: out_ready=1, in_f=0x0000_00FF, 0xFFFF_0000, 0x0 on consecutive cycles → outputs one cycle later in order; zero/neg = 0/0, 0/1, 1/0; in_ready stays 1.
- Back-pressure: out_ready=0, send tags 3 then 7 → out_tag=3 held, in_ready=0 after second accept. Raise out_ready → tag 3 then tag 7 out, in_ready=1 again.
- Stall counter: hold out_ready=0 with valid data for 10 cycles → stall_cnt=10. Assert stat_clr during a stall cycle → 0. With STALL_W=3, 12 stall cycles → stall_cnt=7.
- Simultaneous accept and deliver in ONE: out_ready=1, new in_f=0xA5A5_A5A5 → main reloaded, state stays ONE, no skid use.
- With LOGIC_RESULT_PARITY_EN: in_f=0x0000_0007 → out_par=1; in_f=0x0000_0003 → out_par=0.
